pipe_in_fifo: RTL

PIPE_IN_FIFO -- requirements
Module: pipe_in_fifo

---
 rtl/pipe_in_fifo_pkg.sv | 10 +
 rtl/sdp_ram.sv | 35 +++
 rtl/pipe_in_fifo.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipe_in_fifo_pkg.sv
// rtl/pipe_in_fifo_pkg.sv - shared widths and default sizing for the pipe-in FIFO.
package pipe_in_fifo_pkg;

  localparam int DATA_W          = 32;
  localparam int DEPTH_LOG2_DEF  = 10;
  localparam int BLOCK_WORDS_DEF = 256;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one registered read port.
module sdp_ram
  import pipe_in_fifo_pkg::*;
#(
  parameter int ADDR_W = DEPTH_LOG2_DEF,
  parameter int WIDTH  = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register holds its value while rd_en is low, so it doubles as a stall-safe output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pipe_in_fifo.sv
// rtl/pipe_in_fifo.sv - block-throttled pipe-in FIFO with registered output and drop counting.
module pipe_in_fifo
  import pipe_in_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  pipe_in_write,
  input  logic [DATA_W-1:0]     pipe_in_data,
  output logic                  pipe_in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [31:0]           overflow_count
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_V = PW'(2 ** DEPTH_LOG2);
  localparam logic [PW-1:0] BLOCK_V = PW'(BLOCK_WORDS);

  // wptr: next write slot; wptr_vis: wptr one cycle late, the only view the read side gets;
  // rptr: next RAM read; hptr: head word, advanced when the consumer takes it.
  logic [PW-1:0] wptr;
  logic [PW-1:0] wptr_vis;
  logic [PW-1:0] rptr;
  logic [PW-1:0] hptr;
  logic [PW-1:0] level_next;
  logic          full;
  logic          wr_ok;
  logic          pop;
  logic          rd_en;

  assign full  = (wptr[PW-1] != hptr[PW-1]) && (wptr[PW-2:0] == hptr[PW-2:0]);
  assign pop   = out_valid && out_ready;
  assign wr_ok = pipe_in_write && !full && !flush;
  assign rd_en = !flush && (rptr != wptr_vis) && (!out_valid || out_ready);
  assign level = wptr - hptr;

  always_comb begin
    level_next = '0;
    if (!flush) begin
      level_next = (wptr + PW'(wr_ok)) - (hptr + PW'(pop));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr           <= '0;
      wptr_vis       <= '0;
      rptr           <= '0;
      hptr           <= '0;
      out_valid      <= 1'b0;
      pipe_in_ready  <= 1'b0;
      overflow_count <= '0;
    end else begin
      pipe_in_ready <= (DEPTH_V - level_next) >= BLOCK_V;
      if (flush) begin
        wptr      <= '0;
        wptr_vis  <= '0;
        rptr      <= '0;
        hptr      <= '0;
        out_valid <= 1'b0;
      end else begin
        wptr_vis <= wptr;
        if (wr_ok) begin
          wptr <= wptr + 1'b1;
        end
        if (pipe_in_write && full && (overflow_count != 32'hFFFF_FFFF)) begin
          overflow_count <= overflow_count + 32'd1;
        end
        if (rd_en) begin
          rptr <= rptr + 1'b1;
        end
        if (pop) begin
          hptr <= hptr + 1'b1;
        end
        if (rd_en) begin
          out_valid <= 1'b1;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  sdp_ram #(
    .ADDR_W (DEPTH_LOG2),
    .WIDTH  (DATA_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wptr[PW-2:0]),
    .wr_data (pipe_in_data),
    .rd_en   (rd_en),
    .rd_addr (rptr[PW-2:0]),
    .rd_data (out_data)
  );

endmodule
